// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the register-file read stage.
package pipe_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned AW       = $clog2(NREGS);
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_read_if.sv
// Writeback, read-request and operand-bundle signals of the register-file read stage.
interface regfile_read_if #(
  parameter int unsigned XLEN = pipe_pkg::XLEN,
  parameter int unsigned AW   = pipe_pkg::AW
);

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  logic            rd_valid;
  logic            rd_ready;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd_dest;

  logic            op_valid;
  logic            op_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [AW-1:0]   op_dest;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_valid, rs1, rs2, rd_dest,
    input  rd_ready,
    input  op_valid, op_a, op_b, op_dest,
    output op_ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_valid, rs1, rs2, rd_dest,
    output rd_ready,
    output op_valid, op_a, op_b, op_dest,
    input  op_ready
  );

endinterface

// File: rtl/regfile_mem.sv
// NREGS x XLEN register storage: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear; register 0 is hardwired to zero.
module regfile_mem #(
  parameter int unsigned XLEN  = pipe_pkg::XLEN,
  parameter int unsigned NREGS = pipe_pkg::NREGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  import pipe_pkg::*;

  logic [XLEN-1:0] mem [NREGS];

  logic wr_hit;
  assign wr_hit = we && (waddr != AW'(ZERO_REG)) && ({1'b0, waddr} < (AW+1)'(NREGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_hit) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses (non-power-of-two NREGS) read as zero like r0.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != AW'(ZERO_REG) && ({1'b0, raddr_a} < (AW+1)'(NREGS))) rdata_a = mem[raddr_a];
    if (raddr_b != AW'(ZERO_REG) && ({1'b0, raddr_b} < (AW+1)'(NREGS))) rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/regfile_read.sv
// Register-file read stage: valid/ready request in, registered operand bundle out.
// Define REGFILE_READ_BYPASS_EN to forward a same-cycle writeback into the captured operands.
module regfile_read #(
  parameter int unsigned XLEN  = pipe_pkg::XLEN,
  parameter int unsigned NREGS = pipe_pkg::NREGS
) (
  input logic           clk,
  input logic           rst_n,
  regfile_read_if.slave bus
);

  import pipe_pkg::*;

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] rdata_a;
  logic [XLEN-1:0] rdata_b;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;

  logic            valid_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [AW-1:0]   dest_q;

  logic accept;

  regfile_mem #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.wr_en),
    .waddr   (bus.wr_addr),
    .wdata   (bus.wr_data),
    .raddr_a (bus.rs1),
    .raddr_b (bus.rs2),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  assign bus.rd_ready = !valid_q || bus.op_ready;
  assign accept       = bus.rd_valid && bus.rd_ready;

`ifdef REGFILE_READ_BYPASS_EN
  logic wr_live;
  assign wr_live = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));

  always_comb begin
    src_a = rdata_a;
    src_b = rdata_b;
    if (wr_live && (bus.wr_addr == bus.rs1)) src_a = bus.wr_data;
    if (wr_live && (bus.wr_addr == bus.rs2)) src_b = bus.wr_data;
  end
`else
  assign src_a = rdata_a;
  assign src_b = rdata_b;
`endif

  // A drain without a new accept only drops valid; data stays to keep outputs quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dest_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      a_q     <= src_a;
      b_q     <= src_b;
      dest_q  <= bus.rd_dest;
    end else if (bus.op_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.op_valid = valid_q;
  assign bus.op_a     = a_q;
  assign bus.op_b     = b_q;
  assign bus.op_dest  = dest_q;

endmodule

// File: tb/tb_regfile_read.sv
// Directed self-checking bench for regfile_read; expectations follow REGFILE_READ_BYPASS_EN.
module tb_regfile_read;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_read_if #(.XLEN(32), .AW(5)) bus ();

  regfile_read #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_req(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    bus.rd_valid = 1'b1;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.rd_dest  = d;
    tick();
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bypass_exp;
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_valid = 1'b0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.rd_dest  = '0;
    bus.op_ready = 1'b1;

    tick();
    tick();
    check("rst_op_valid", 64'(bus.op_valid), 64'd0);
    check("rst_op_a",     64'(bus.op_a),     64'd0);
    check("rst_op_b",     64'(bus.op_b),     64'd0);
    check("rst_op_dest",  64'(bus.op_dest),  64'd0);
    check("rst_rd_ready", 64'(bus.rd_ready), 64'd1);

    // First accept on the first posedge after reset release
    rst_n = 1'b1;
    read_req(5'd3, 5'd0, 5'd4);
    check("first_valid", 64'(bus.op_valid), 64'd1);
    check("first_op_a",  64'(bus.op_a),     64'd0);
    check("first_op_b",  64'(bus.op_b),     64'd0);
    check("first_dest",  64'(bus.op_dest),  64'd4);
    tick();
    check("drain_valid", 64'(bus.op_valid), 64'd0);

    // Write then read, including rs1==rs2
    write_reg(5'd5, 32'hDEAD_BEEF);
    read_req(5'd5, 5'd5, 5'd1);
    check("wr_rd_op_a", 64'(bus.op_a), 64'hDEAD_BEEF);
    check("wr_rd_op_b", 64'(bus.op_b), 64'hDEAD_BEEF);
    write_reg(5'd1, 32'h1111_1111);
    write_reg(5'd2, 32'h2222_2222);
    read_req(5'd1, 5'd2, 5'd2);
    check("pair_op_a", 64'(bus.op_a), 64'h1111_1111);
    check("pair_op_b", 64'(bus.op_b), 64'h2222_2222);
    tick();

    // Same-cycle write and accept to r7
    write_reg(5'd7, 32'd1);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 32'd9;
`ifdef REGFILE_READ_BYPASS_EN
    bypass_exp = 32'd9;
`else
    bypass_exp = 32'd1;
`endif
    read_req(5'd7, 5'd7, 5'd7);
    bus.wr_en = 1'b0;
    check("bypass_op_a", 64'(bus.op_a), 64'(bypass_exp));
    check("bypass_op_b", 64'(bus.op_b), 64'(bypass_exp));
    read_req(5'd7, 5'd0, 5'd7);
    check("bypass_later", 64'(bus.op_a), 64'd9);
    tick();

    // Stall: held bundle must ignore later writes and new requests
    bus.op_ready = 1'b0;
    read_req(5'd5, 5'd1, 5'd10);
    bus.rd_valid = 1'b1;
    bus.rs1      = 5'd2;
    bus.rd_dest  = 5'd11;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_op_a",     64'(bus.op_a),     64'hDEAD_BEEF);
      check("stall_dest",     64'(bus.op_dest),  64'd10);
      check("stall_valid",    64'(bus.op_valid), 64'd1);
      check("stall_rd_ready", 64'(bus.rd_ready), 64'd0);
    end
    bus.rd_valid = 1'b0;
    bus.wr_en    = 1'b0;
    bus.op_ready = 1'b1;
    tick();
    check("unstall_valid", 64'(bus.op_valid), 64'd0);
    read_req(5'd5, 5'd0, 5'd0);
    check("stall_write_landed", 64'(bus.op_a), 64'h1234_5678);
    tick();

    // Throughput: 8 back-to-back requests
    for (int i = 0; i < 8; i++) write_reg(5'(8 + i), 32'hA000_0000 + 32'(i));
    bus.rd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rs1     = 5'(8 + i);
      bus.rs2     = 5'(15 - i);
      bus.rd_dest = 5'(16 + i);
      tick();
      check("tput_valid", 64'(bus.op_valid), 64'd1);
      check("tput_op_a",  64'(bus.op_a),     64'hA000_0000 + 64'(i));
      check("tput_op_b",  64'(bus.op_b),     64'hA000_0000 + 64'(7 - i));
      check("tput_dest",  64'(bus.op_dest),  64'(16 + i));
    end
    bus.rd_valid = 1'b0;
    tick();
    check("tput_drain", 64'(bus.op_valid), 64'd0);

    // Zero register ignores writes
    write_reg(5'd0, 32'hFF);
    read_req(5'd0, 5'd0, 5'd0);
    check("r0_op_a", 64'(bus.op_a), 64'd0);
    check("r0_op_b", 64'(bus.op_b), 64'd0);
    tick();

    // Reset mid-stall drops the bundle immediately and blocks writes
    bus.op_ready = 1'b0;
    read_req(5'd5, 5'd1, 5'd3);
    check("pre_rst_valid", 64'(bus.op_valid), 64'd1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.op_valid), 64'd0);
    check("mid_rst_op_a",  64'(bus.op_a),     64'd0);
    check("mid_rst_dest",  64'(bus.op_dest),  64'd0);
    tick();
    bus.wr_en    = 1'b0;
    rst_n        = 1'b1;
    bus.op_ready = 1'b1;
    read_req(5'd9, 5'd5, 5'd6);
    check("post_rst_r9",    64'(bus.op_a),     64'd0);
    check("post_rst_r5",    64'(bus.op_b),     64'd0);
    check("post_rst_valid", 64'(bus.op_valid), 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_read.md
REGFILE_READ -- requirements
Module: regfile_read

Interface
REQ-001 Parameter XLEN, default 32: data width of each register and operand.
REQ-002 Parameter NREGS, default 32: register count; address width is clog2(NREGS), i.e. 5 at default.
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port wr_en  input  1: writeback write strobe.
REQ-006 Port wr_addr  input  5: writeback destination register.
REQ-007 Port wr_data  input  XLEN: writeback data.
REQ-008 Port rd_valid  input  1: read request valid.
REQ-009 Port rd_ready  output  1: block accepts a read request this cycle.
REQ-010 Port rs1, rs2  input  5 each: source register addresses.
REQ-011 Port rd_dest  input  5: destination tag, passed through unchanged.
REQ-012 Port op_valid  output  1: operand bundle valid.
REQ-013 Port op_ready  input  1: downstream (execute) accepts the bundle.
REQ-014 Port op_a, op_b  output  XLEN each: operand values for rs1 and rs2.
REQ-015 Port op_dest  output  5: captured rd_dest.

Function
REQ-016 Storage shall be NREGS x XLEN; register 0 shall read as 0, and writes to it shall be ignored.
REQ-017 A write shall occur on a posedge when wr_en=1 and wr_addr!=0, independent of the read handshake.
REQ-018 rd_ready shall equal (!op_valid || op_ready), combinationally.
REQ-019 The block shall accept a request on a posedge with rd_valid && rd_ready.
REQ-020 On accept, op_a/op_b/op_dest shall be captured into an output register, and op_valid=1 on the next cycle (latency 1).
REQ-021 If op_valid && op_ready with no new accept, op_valid shall go to 0.
REQ-022 Accept and drain in the same cycle shall keep op_valid=1 and load the new bundle, giving one request per cycle throughput.
REQ-023 While op_valid && !op_ready, op_a/op_b/op_dest shall hold stable; later writes shall not alter held operands.
REQ-024 Same-cycle write and accept to a matching nonzero address: behaviour is set by REQ-029/REQ-030.
REQ-025 rs1==rs2 shall return identical values on op_a and op_b.

Reset
REQ-026 While rst_n=0: op_valid=0, op_a=0, op_b=0, op_dest=0, and all registers=0.
REQ-027 Reset asserted mid-transaction shall discard any held bundle immediately; no write shall occur while rst_n=0.
REQ-028 The first accept shall be possible on the first posedge after rst_n deasserts.

Configuration
REQ-029 With macro REGFILE_READ_BYPASS_EN defined: a same-cycle matching write shall be forwarded, so the captured operand equals wr_data.
REQ-030 Without REGFILE_READ_BYPASS_EN: the captured operand shall be the pre-write stored value; the write still lands.

Structure
REQ-031 XLEN, NREGS, the register address width and the zero-register index shall live in shared package pipe_pkg.
REQ-032 Storage plus write logic shall be one sub-module, regfile_mem (2 asynchronous read ports, 1 synchronous write port, async reset).
REQ-033 The handshake, bypass mux and output register shall live in regfile_read.

Verification
REQ-034 Reset scenario: after reset, accept rs1=3, rs2=0 -> op_a=0, op_b=0, op_valid=1 one cycle later.
REQ-035 Write/read scenario: write r5=0xDEAD_BEEF, then on the next cycle read rs1=5 -> op_a=0xDEADBEEF.
REQ-036 Bypass scenario: r7=1; in the same cycle write r7=9 and accept rs1=7 -> op_a=9 with the macro, op_a=1 without; a later read gives 9 in both builds.
REQ-037 Stall scenario: hold op_ready=0 for 3 cycles and write the held source register -> op_a unchanged, rd_ready=0, op_valid stays 1.
REQ-038 Throughput scenario: op_ready=1 with 8 back-to-back requests -> 8 bundles on consecutive cycles in order, with op_dest matching each request.
REQ-039 Zero-register and reset scenario: write r0=0xFF, then read rs1=0 -> op_a=0; assert rst_n=0 mid-stall -> op_valid=0 at once.
